// File: rtl/axi4_mgr_arb.sv
// Round-robin arbiter sharing one axi4_mgr between NUM_REQ requesters.
// Write and read channels each run an independent IDLE/BUSY/RESP sequencer.
module axi4_mgr_arb #(
    parameter int NUM_REQ          = 4,
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_DATA_WIDTH   = 64,
    parameter int DATA_COUNT_WIDTH = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rstn_i,
    input  logic [NUM_REQ-1:0]                    wr_req_i,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]     wr_addr_i,
    input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]     wr_data_i,
    input  logic [NUM_REQ*DATA_COUNT_WIDTH-1:0]   wr_count_i,
    output logic [NUM_REQ-1:0]                    wr_gnt_o,
    output logic [NUM_REQ-1:0]                    wr_done_o,
    output logic [1:0]                            wr_err_o,
    input  logic [NUM_REQ-1:0]                    rd_req_i,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]     rd_addr_i,
    input  logic [NUM_REQ*DATA_COUNT_WIDTH-1:0]   rd_count_i,
    output logic [NUM_REQ-1:0]                    rd_gnt_o,
    output logic [NUM_REQ-1:0]                    rd_done_o,
    output logic [1:0]                            rd_err_o,
    output logic [AXI_DATA_WIDTH-1:0]             rd_data_o,
    output logic [1:0]                            mgr_req_o,
    output logic [AXI_ADDR_WIDTH-1:0]             mgr_wr_addr_o,
    output logic [AXI_ADDR_WIDTH-1:0]             mgr_rd_addr_o,
    output logic [AXI_DATA_WIDTH-1:0]             mgr_data_o,
    output logic [DATA_COUNT_WIDTH-1:0]           mgr_wr_count_o,
    output logic [DATA_COUNT_WIDTH-1:0]           mgr_rd_count_o,
    input  logic [1:0]                            mgr_rsp_i,
    input  logic [1:0]                            mgr_wr_err_i,
    input  logic [1:0]                            mgr_rd_err_i,
    input  logic [AXI_DATA_WIDTH-1:0]             mgr_data_i
);

    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW  = AXI_ADDR_WIDTH;
    localparam int DW  = AXI_DATA_WIDTH;
    localparam int DCW = DATA_COUNT_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    // First set request strictly after the pointer, wrapping round.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IW-1:0]      ptr);
        logic [IW-1:0] win;
        logic [IW-1:0] idx;
        win = ptr;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = IW'((int'(ptr) + off) % NUM_REQ);
            if (req[idx]) win = idx;
        end
        return win;
    endfunction

    logic [AW-1:0]  wr_addr_a  [NUM_REQ];
    logic [AW-1:0]  rd_addr_a  [NUM_REQ];
    logic [DW-1:0]  wr_data_a  [NUM_REQ];
    logic [DCW-1:0] wr_count_a [NUM_REQ];
    logic [DCW-1:0] rd_count_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign wr_addr_a[g]  = wr_addr_i[g*AW +: AW];
        assign rd_addr_a[g]  = rd_addr_i[g*AW +: AW];
        assign wr_data_a[g]  = wr_data_i[g*DW +: DW];
        assign wr_count_a[g] = wr_count_i[g*DCW +: DCW];
        assign rd_count_a[g] = rd_count_i[g*DCW +: DCW];
    end

    state_e               wr_state_q, wr_state_d, rd_state_q, rd_state_d;
    logic [IW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_win, rd_win;
    logic [NUM_REQ-1:0]   wr_gnt_q, wr_gnt_d, rd_gnt_q, rd_gnt_d;
    logic [NUM_REQ-1:0]   wr_done_q, wr_done_d, rd_done_q, rd_done_d;
    logic [1:0]           wr_err_q, wr_err_d, rd_err_q, rd_err_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DCW-1:0]       wr_count_q, wr_count_d, rd_count_q, rd_count_d;
    logic                 wr_mreq_q, wr_mreq_d, rd_mreq_q, rd_mreq_d;
    logic [DW-1:0]        rd_data_q, rd_data_d;

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_gnt_d   = wr_gnt_q;
        wr_done_d  = wr_done_q;
        wr_err_d   = wr_err_q;
        wr_addr_d  = wr_addr_q;
        wr_count_d = wr_count_q;
        wr_mreq_d  = wr_mreq_q;
        wr_win     = rr_pick(wr_req_i, wr_ptr_q);
        unique case (wr_state_q)
            IDLE: if (|wr_req_i) begin
                wr_ptr_d   = wr_win;
                wr_gnt_d   = NUM_REQ'(1) << wr_win;
                wr_addr_d  = wr_addr_a[wr_win];
                wr_count_d = wr_count_a[wr_win];
                if (wr_count_a[wr_win] != '0) begin
                    wr_state_d = BUSY;
                    wr_mreq_d  = 1'b1;
                end else begin
                    wr_state_d = RESP;
                    wr_err_d   = 2'b00;
                    wr_done_d  = wr_gnt_d;
                end
            end
            BUSY: if (mgr_rsp_i[0]) begin
                wr_state_d = RESP;
                wr_mreq_d  = 1'b0;
                wr_err_d   = mgr_wr_err_i;
                wr_done_d  = wr_gnt_q;
            end
            RESP: begin
                wr_state_d = IDLE;
                wr_done_d  = '0;
                wr_gnt_d   = '0;
            end
            default: wr_state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_ptr_d   = rd_ptr_q;
        rd_gnt_d   = rd_gnt_q;
        rd_done_d  = rd_done_q;
        rd_err_d   = rd_err_q;
        rd_addr_d  = rd_addr_q;
        rd_count_d = rd_count_q;
        rd_mreq_d  = rd_mreq_q;
        rd_data_d  = rd_data_q;
        rd_win     = rr_pick(rd_req_i, rd_ptr_q);
        unique case (rd_state_q)
            IDLE: if (|rd_req_i) begin
                rd_ptr_d   = rd_win;
                rd_gnt_d   = NUM_REQ'(1) << rd_win;
                rd_addr_d  = rd_addr_a[rd_win];
                rd_count_d = rd_count_a[rd_win];
                if (rd_count_a[rd_win] != '0) begin
                    rd_state_d = BUSY;
                    rd_mreq_d  = 1'b1;
                end else begin
                    rd_state_d = RESP;
                    rd_err_d   = 2'b00;
                    rd_done_d  = rd_gnt_d;
                end
            end
            BUSY: if (mgr_rsp_i[1]) begin
                rd_state_d = RESP;
                rd_mreq_d  = 1'b0;
                rd_err_d   = mgr_rd_err_i;
                rd_data_d  = mgr_data_i;
                rd_done_d  = rd_gnt_q;
            end
            RESP: begin
                rd_state_d = IDLE;
                rd_done_d  = '0;
                rd_gnt_d   = '0;
            end
            default: rd_state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the latched outputs are reset too because they drive ports.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_state_q <= IDLE;
            rd_state_q <= IDLE;
            wr_ptr_q   <= IW'(NUM_REQ - 1);
            rd_ptr_q   <= IW'(NUM_REQ - 1);
            wr_gnt_q   <= '0;
            rd_gnt_q   <= '0;
            wr_done_q  <= '0;
            rd_done_q  <= '0;
            wr_err_q   <= '0;
            rd_err_q   <= '0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_count_q <= '0;
            rd_count_q <= '0;
            wr_mreq_q  <= 1'b0;
            rd_mreq_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
            wr_err_q   <= wr_err_d;
            rd_err_q   <= rd_err_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
            wr_mreq_q  <= wr_mreq_d;
            rd_mreq_q  <= rd_mreq_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // While granted, the pointer equals the owner, so it selects the write data.
    assign mgr_data_o     = (|wr_gnt_q) ? wr_data_a[wr_ptr_q] : '0;
    assign wr_gnt_o       = wr_gnt_q;
    assign wr_done_o      = wr_done_q;
    assign wr_err_o       = wr_err_q;
    assign rd_gnt_o       = rd_gnt_q;
    assign rd_done_o      = rd_done_q;
    assign rd_err_o       = rd_err_q;
    assign rd_data_o      = rd_data_q;
    assign mgr_req_o      = {rd_mreq_q, wr_mreq_q};
    assign mgr_wr_addr_o  = wr_addr_q;
    assign mgr_rd_addr_o  = rd_addr_q;
    assign mgr_wr_count_o = wr_count_q;
    assign mgr_rd_count_o = rd_count_q;

endmodule

// File: tb/tb_axi4_mgr_arb.sv
// Self-checking bench for axi4_mgr_arb: transaction-level model compared every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_axi4_mgr_arb;

    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int DCW = 8;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [N-1:0]     wr_req_i, rd_req_i;
    logic [AW-1:0]    wr_addr_a [N];
    logic [AW-1:0]    rd_addr_a [N];
    logic [DW-1:0]    wr_data_a [N];
    logic [DCW-1:0]   wr_count_a [N];
    logic [DCW-1:0]   rd_count_a [N];
    logic [N*AW-1:0]  wr_addr_i, rd_addr_i;
    logic [N*DW-1:0]  wr_data_i;
    logic [N*DCW-1:0] wr_count_i, rd_count_i;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign wr_addr_i[g*AW +: AW]    = wr_addr_a[g];
        assign rd_addr_i[g*AW +: AW]    = rd_addr_a[g];
        assign wr_data_i[g*DW +: DW]    = wr_data_a[g];
        assign wr_count_i[g*DCW +: DCW] = wr_count_a[g];
        assign rd_count_i[g*DCW +: DCW] = rd_count_a[g];
    end

    logic [N-1:0]   wr_gnt_o, wr_done_o, rd_gnt_o, rd_done_o;
    logic [1:0]     wr_err_o, rd_err_o, mgr_req_o;
    logic [DW-1:0]  rd_data_o, mgr_data_o;
    logic [AW-1:0]  mgr_wr_addr_o, mgr_rd_addr_o;
    logic [DCW-1:0] mgr_wr_count_o, mgr_rd_count_o;
    logic [1:0]     mgr_rsp_i    = 2'b00;
    logic [1:0]     mgr_wr_err_i = 2'b00;
    logic [1:0]     mgr_rd_err_i = 2'b00;
    logic [DW-1:0]  mgr_data_i   = '0;

    axi4_mgr_arb #(
        .NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .DATA_COUNT_WIDTH(DCW)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .wr_count_i(wr_count_i), .wr_gnt_o(wr_gnt_o), .wr_done_o(wr_done_o),
        .wr_err_o(wr_err_o),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_count_i(rd_count_i),
        .rd_gnt_o(rd_gnt_o), .rd_done_o(rd_done_o), .rd_err_o(rd_err_o),
        .rd_data_o(rd_data_o),
        .mgr_req_o(mgr_req_o), .mgr_wr_addr_o(mgr_wr_addr_o),
        .mgr_rd_addr_o(mgr_rd_addr_o), .mgr_data_o(mgr_data_o),
        .mgr_wr_count_o(mgr_wr_count_o), .mgr_rd_count_o(mgr_rd_count_o),
        .mgr_rsp_i(mgr_rsp_i), .mgr_wr_err_i(mgr_wr_err_i),
        .mgr_rd_err_i(mgr_rd_err_i), .mgr_data_i(mgr_data_i)
    );

    // Manager stand-in: answers each request a programmable number of cycles later.
    int            wr_lat = 2, rd_lat = 2, wr_wait = 0, rd_wait = 0;
    logic [1:0]    wr_err_val = 2'b00, rd_err_val = 2'b00;
    logic [DW-1:0] rd_data_val = '0;

    always @(negedge clk_i) begin
        mgr_rsp_i    = 2'b00;
        mgr_wr_err_i = 2'b11;
        mgr_rd_err_i = 2'b11;
        mgr_data_i   = ~rd_data_val;
        if (mgr_req_o[0]) begin
            wr_wait++;
            if (wr_wait >= wr_lat) begin
                mgr_rsp_i[0] = 1'b1;
                mgr_wr_err_i = wr_err_val;
                wr_wait      = 0;
            end
        end else wr_wait = 0;
        if (mgr_req_o[1]) begin
            rd_wait++;
            if (rd_wait >= rd_lat) begin
                mgr_rsp_i[1] = 1'b1;
                mgr_rd_err_i = rd_err_val;
                mgr_data_i   = rd_data_val;
                rd_wait      = 0;
            end
        end else rd_wait = 0;
    end

    // Behavioural model, channel 0 = write, 1 = read. m_own is the owning
    // requester (-1 when free); m_resp marks the completion cycle.
    int             m_own [2];
    int             m_last [2];
    bit             m_mreq [2];
    bit             m_resp [2];
    logic [N-1:0]   m_done [2];
    logic [1:0]     m_err [2];
    logic [AW-1:0]  m_addr [2];
    logic [DCW-1:0] m_cnt [2];
    logic [DW-1:0]  m_rdata;

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < 2; c++) begin
                m_own[c]  = -1;
                m_last[c] = N - 1;
                m_mreq[c] = 1'b0;
                m_resp[c] = 1'b0;
                m_done[c] = '0;
                m_err[c]  = '0;
                m_addr[c] = '0;
                m_cnt[c]  = '0;
            end
            m_rdata = '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                logic [N-1:0]  req;
                logic [IW-1:0] idx;
                int            w;
                req = (c == 0) ? wr_req_i : rd_req_i;
                if (m_resp[c]) begin
                    m_resp[c] = 1'b0;
                    m_done[c] = '0;
                    m_own[c]  = -1;
                end else if (m_own[c] < 0) begin
                    if (req != '0) begin
                        w = -1;
                        for (int off = 1; off <= N; off++) begin
                            idx = IW'((m_last[c] + off) % N);
                            if (w < 0 && req[idx]) w = int'(idx);
                        end
                        idx       = IW'(w);
                        m_own[c]  = w;
                        m_last[c] = w;
                        m_addr[c] = (c == 0) ? wr_addr_a[idx] : rd_addr_a[idx];
                        m_cnt[c]  = (c == 0) ? wr_count_a[idx] : rd_count_a[idx];
                        if (m_cnt[c] == '0) begin
                            m_resp[c] = 1'b1;
                            m_err[c]  = 2'b00;
                            m_done[c] = N'(1) << w;
                        end else m_mreq[c] = 1'b1;
                    end
                end else if (mgr_rsp_i[c]) begin
                    m_mreq[c] = 1'b0;
                    m_err[c]  = (c == 0) ? mgr_wr_err_i : mgr_rd_err_i;
                    if (c == 1) m_rdata = mgr_data_i;
                    m_done[c] = N'(1) << m_own[c];
                    m_resp[c] = 1'b1;
                end
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 'h%0h, expected 'h%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int o);
        return (o < 0) ? '0 : N'(1) << o;
    endfunction

    task automatic compare_model();
        logic [DW-1:0] exp_data;
        exp_data = (m_own[0] < 0) ? '0 : wr_data_a[IW'(m_own[0])];
        check("mgr_req",      mgr_req_o,      {m_mreq[1], m_mreq[0]});
        check("wr_gnt",       wr_gnt_o,       onehot(m_own[0]));
        check("rd_gnt",       rd_gnt_o,       onehot(m_own[1]));
        check("wr_done",      wr_done_o,      m_done[0]);
        check("rd_done",      rd_done_o,      m_done[1]);
        check("wr_err",       wr_err_o,       m_err[0]);
        check("rd_err",       rd_err_o,       m_err[1]);
        check("rd_data",      rd_data_o,      m_rdata);
        check("mgr_wr_addr",  mgr_wr_addr_o,  m_addr[0]);
        check("mgr_rd_addr",  mgr_rd_addr_o,  m_addr[1]);
        check("mgr_wr_count", mgr_wr_count_o, m_cnt[0]);
        check("mgr_rd_count", mgr_rd_count_o, m_cnt[1]);
        check("mgr_data",     mgr_data_o,     exp_data);
    endtask

    logic [N-1:0] wr_done_seen = '0, rd_done_seen = '0, prev_wr_gnt = '0;
    int           wr_done_total [N];
    int           gnt_order [$];

    // One clock: compare just after the rising edge, return on the falling edge.
    task automatic step();
        @(posedge clk_i);
        #1;
        compare_model();
        wr_done_seen = wr_done_o;
        rd_done_seen = rd_done_o;
        for (int i = 0; i < N; i++) if (wr_done_o[i]) wr_done_total[i]++;
        if (wr_gnt_o != '0 && prev_wr_gnt == '0)
            for (int i = 0; i < N; i++) if (wr_gnt_o[i]) gnt_order.push_back(i);
        prev_wr_gnt = wr_gnt_o;
        @(negedge clk_i);
    endtask

    task automatic wait_done(input bit rd, input int idx);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            step();
            seen = rd ? rd_done_seen[idx] : wr_done_seen[idx];
        end
        check(rd ? "rd_done_timeout" : "wr_done_timeout", 64'(seen), 64'd1);
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};
    int base, total;

    initial begin
        wr_req_i = '0;
        rd_req_i = '0;
        for (int i = 0; i < N; i++) begin
            wr_addr_a[i]     = '0;
            rd_addr_a[i]     = '0;
            wr_data_a[i]     = 64'hA5A5_0000_0000_0000 | 64'(i + 1);
            wr_count_a[i]    = '0;
            rd_count_a[i]    = '0;
            wr_done_total[i] = 0;
        end

        // Reset holds everything at zero; release shows no activity without requests.
        repeat (3) step();
        check("reset_mgr_req", mgr_req_o, 2'b00);
        check("reset_wr_done", wr_done_o, '0);
        rstn_i = 1'b1;
        repeat (3) step();
        check("idle_mgr_req", mgr_req_o, 2'b00);
        check("idle_wr_gnt", wr_gnt_o, '0);

        // All four held: rotation starts at requester 0 after reset.
        for (int i = 0; i < N; i++) begin
            wr_addr_a[i]  = 32'h1000 * (i + 1);
            wr_count_a[i] = DCW'(i + 1);
        end
        wr_lat = 2;
        gnt_order.delete();
        wr_req_i = 4'b1111;
        total = 0;
        for (int k = 0; k < 200 && total < 5; k++) begin
            step();
            total = 0;
            for (int i = 0; i < N; i++) total += wr_done_total[i];
        end
        wr_req_i = '0;
        repeat (3) step();
        check("rr_count", 64'(gnt_order.size()), 64'd5);
        for (int i = 0; i < 5 && i < gnt_order.size(); i++)
            check("rr_order", 64'(gnt_order[i]), 64'(exp_order[i]));

        // Single write from requester 2, answered five cycles later.
        wr_addr_a[2]  = 32'h5000;
        wr_count_a[2] = 8'd7;
        wr_lat        = 5;
        base          = wr_done_total[2];
        wr_req_i      = 4'b0100;
        step();
        check("t2_mgr_req0", 64'(mgr_req_o[0]), 64'd1);
        check("t2_addr", mgr_wr_addr_o, 32'h5000);
        check("t2_count", mgr_wr_count_o, 8'd7);
        check("t2_gnt", wr_gnt_o, 4'b0100);
        check("t2_data", mgr_data_o, 64'hA5A5_0000_0000_0003);
        wait_done(1'b0, 2);
        wr_req_i = '0;
        repeat (3) step();
        check("t2_done_once", 64'(wr_done_total[2] - base), 64'd1);
        check("t2_gnt_clear", wr_gnt_o, '0);

        // Concurrent read and write with simultaneous responses.
        rd_addr_a[1]  = 32'h6000;
        rd_count_a[1] = 8'd4;
        wr_addr_a[3]  = 32'h7000;
        wr_count_a[3] = 8'd2;
        rd_lat        = 3;
        wr_lat        = 3;
        rd_err_val    = 2'b10;
        wr_err_val    = 2'b01;
        rd_data_val   = 64'hDEAD_BEEF_0B50_1E7E;
        rd_req_i      = 4'b0010;
        wr_req_i      = 4'b1000;
        step();
        check("t4_mgr_req", mgr_req_o, 2'b11);
        check("t4_rd_addr", mgr_rd_addr_o, 32'h6000);
        wait_done(1'b1, 1);
        check("t4_rd_done", rd_done_o, 4'b0010);
        check("t4_rd_data", rd_data_o, 64'hDEAD_BEEF_0B50_1E7E);
        check("t4_rd_err", rd_err_o, 2'b10);
        check("t4_wr_done", wr_done_o, 4'b1000);
        check("t4_wr_err", wr_err_o, 2'b01);
        rd_req_i = '0;
        wr_req_i = '0;
        repeat (2) step();

        // Zero-length read never touches the manager.
        rd_addr_a[0]  = 32'h8000;
        rd_count_a[0] = 8'd0;
        rd_req_i      = 4'b0001;
        step();
        check("t5_rd_done", rd_done_o, 4'b0001);
        check("t5_rd_err", rd_err_o, 2'b00);
        check("t5_mgr_req1", 64'(mgr_req_o[1]), 64'd0);
        rd_req_i = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5_mgr_req1_idle", 64'(mgr_req_o[1]), 64'd0);
        end

        // Reset while BUSY aborts at once and restores the pointer.
        wr_addr_a[0]  = 32'h9000;
        wr_count_a[0] = 8'd5;
        wr_count_a[1] = 8'd5;
        wr_lat        = 20;
        wr_req_i      = 4'b0001;
        repeat (2) step();
        check("t6_busy", 64'(mgr_req_o[0]), 64'd1);
        rstn_i = 1'b0;
        #1;
        check("t6_async_mgr_req", mgr_req_o, 2'b00);
        check("t6_async_gnt", wr_gnt_o, '0);
        compare_model();
        wr_req_i = '0;
        @(negedge clk_i);
        repeat (2) step();
        rstn_i   = 1'b1;
        wr_lat   = 2;
        wr_req_i = 4'b0011;
        step();
        check("t6_first_winner", wr_gnt_o, 4'b0001);
        wait_done(1'b0, 0);
        wr_req_i = '0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
